// File: rtl/ssd_img_pkg.sv
// Shared types and defaults for the image RAM stream reader.
//   PKG_ADDR_W / PKG_DATA_W / PKG_FIFO_DEPTH : default geometry (64K x 8 RAM, 4-entry skid FIFO)
//   state_e  : reader FSM encoding {IDLE, RUN, DRAIN, DONE}
//   pixel_t  : one FIFO entry, a pixel plus its start/end-of-job tags
//   csum_add : modulo-2^16 byte accumulation used by the optional checksum
package ssd_img_pkg;

    localparam int PKG_ADDR_W     = 16;
    localparam int PKG_DATA_W     = 8;
    localparam int PKG_FIFO_DEPTH = 4;
    localparam int CSUM_W         = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [PKG_DATA_W-1:0] data;
        logic                  sop;
        logic                  eop;
    } pixel_t;

    function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                   input logic [PKG_DATA_W-1:0] b);
        return acc + CSUM_W'(b);
    endfunction

endpackage

// File: rtl/ssd_imagem_stream_reader_if.sv
// Bundle of the reader's job-control, RAM (Avalon-MM s1 read) and pixel-stream signals.
//   control : start, abort, base_addr, length -> reader ; busy, done <- reader
//   ram     : mem_address, mem_chipselect, mem_clken -> RAM ; mem_readdata <- RAM
//   stream  : st_data, st_valid, st_sop, st_eop -> sink ; st_ready <- sink
//   checksum (only with SSD_IMG_RD_CHECKSUM_EN defined) : running byte sum -> observer
// Modports: master = the reader itself, slave = the surrounding system / bench.
interface ssd_imagem_stream_reader_if
    import ssd_img_pkg::*;
#(
    parameter int ADDR_W = PKG_ADDR_W,
    parameter int DATA_W = PKG_DATA_W
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;
    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready;
    logic              st_sop;
    logic              st_eop;
`ifdef SSD_IMG_RD_CHECKSUM_EN
    logic [CSUM_W-1:0] checksum;
`endif

    modport master (
        input  start, abort, base_addr, length, mem_readdata, st_ready,
        output busy, done, mem_address, mem_chipselect, mem_clken,
               st_data, st_valid, st_sop, st_eop
`ifdef SSD_IMG_RD_CHECKSUM_EN
        , output checksum
`endif
    );

    modport slave (
        output start, abort, base_addr, length, mem_readdata, st_ready,
        input  busy, done, mem_address, mem_chipselect, mem_clken,
               st_data, st_valid, st_sop, st_eop
`ifdef SSD_IMG_RD_CHECKSUM_EN
        , input checksum
`endif
    );

endinterface

// File: rtl/ssd_img_fifo.sv
// Synchronous skid FIFO of tagged pixels between the RAM read return and the stream sink.
//   clk, reset : clock, asynchronous active-high reset (pointers/count only)
//   flush      : empties the FIFO on the next edge, dominating push/pop
//   push, din  : write one entry (caller guarantees not full)
//   pop, dout  : dout is the head entry; pop retires it (caller guarantees not empty)
//   count      : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module ssd_img_fifo
    import ssd_img_pkg::*;
#(
    parameter int DEPTH = PKG_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  pixel_t                   din,
    input  logic                     pop,
    output pixel_t                   dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    pixel_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage carries no reset; an entry is only visible once count says so.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + ($clog2(DEPTH)+1)'(1);
                2'b01:   count <= count - ($clog2(DEPTH)+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/ssd_imagem_stream_reader.sv
// Avalon-MM read master for the 8-bit x 64K image RAM that replays a byte range as an
// Avalon-ST pixel stream with SOP/EOP.
//   clk, reset : single clock; asynchronous active-high reset
//   bus        : ssd_imagem_stream_reader_if.master
//                control  start/abort/base_addr/length in, busy/done out
//                RAM      mem_address/mem_chipselect/mem_clken out, mem_readdata in (latency 1)
//                stream   st_data/st_valid/st_sop/st_eop out, st_ready in
// Optional feature: define SSD_IMG_RD_CHECKSUM_EN to add bus.checksum, the modulo-2^16 sum
// of every byte handshaken on the stream (cleared on accepted start, held afterwards).
module ssd_imagem_stream_reader
    import ssd_img_pkg::*;
#(
    parameter int ADDR_W     = PKG_ADDR_W,
    parameter int DATA_W     = PKG_DATA_W,
    parameter int FIFO_DEPTH = PKG_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    ssd_imagem_stream_reader_if.master  bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;
    localparam logic [1:0] S_DONE  = ST_DONE;

    logic [1:0]        state;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W:0]   rem;
    logic              first;

    logic              rd_vld_p0;
    logic              rd_sop_p0;
    logic              rd_eop_p0;

    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    occ;
    pixel_t            fifo_din;
    pixel_t            fifo_dout;
    logic [DATA_W-1:0] head_data;

    logic start_acc;
    logic room;
    logic issue;
    logic last_issue;
    logic fifo_valid;
    logic pop;
    logic push;
    logic flush;
    logic drained;

    assign start_acc  = (state == S_IDLE) && bus.start && !bus.abort;

    // A read is only issued if its byte is guaranteed a FIFO slot on return; the pop
    // happening this cycle is deliberately not credited, which still sustains 1 byte/cycle.
    assign occ        = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_vld_p0};
    assign room       = occ < (CNT_W+1)'(FIFO_DEPTH);
    assign issue      = (state == S_RUN) && !bus.abort && room;
    assign last_issue = issue && (rem == (ADDR_W+1)'(1));

    assign fifo_valid = (fifo_count != '0);
    assign pop        = fifo_valid && bus.st_ready;
    assign push       = rd_vld_p0;
    assign flush      = bus.abort;

    // Leaving DRAIN on the edge that retires the last byte lets done follow the EOP
    // handshake by exactly one cycle.
    assign drained    = !rd_vld_p0 &&
                        ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));

    assign fifo_din   = '{data: bus.mem_readdata, sop: rd_sop_p0, eop: rd_eop_p0};
    assign head_data  = fifo_dout.data;

    ssd_img_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cur       <= '0;
            rem       <= '0;
            first     <= 1'b0;
            rd_vld_p0 <= 1'b0;
            rd_sop_p0 <= 1'b0;
            rd_eop_p0 <= 1'b0;
        end else begin
            // p0: read issued last cycle, RAM data arrives now with these tags
            rd_vld_p0 <= issue;
            rd_sop_p0 <= issue && first;
            rd_eop_p0 <= last_issue;

            case (state)
                S_IDLE: begin
                    if (start_acc) begin
                        cur   <= bus.base_addr;
                        rem   <= bus.length;
                        first <= 1'b1;
                        state <= (bus.length == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        state <= S_IDLE;
                    end else if (issue) begin
                        cur   <= cur + ADDR_W'(1);
                        rem   <= rem - (ADDR_W+1)'(1);
                        first <= 1'b0;
                        if (last_issue) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.abort) begin
                        state <= S_IDLE;
                    end else if (drained) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy           = (state != S_IDLE);
    assign bus.done           = (state == S_DONE) && !bus.abort;
    assign bus.mem_chipselect = issue;
    assign bus.mem_clken      = issue;
    assign bus.mem_address    = issue ? cur : '0;

    // Head fields are forced to zero when empty so idle outputs read as 0.
    assign bus.st_valid       = fifo_valid;
    assign bus.st_data        = fifo_valid ? head_data : '0;
    assign bus.st_sop         = fifo_valid && fifo_dout.sop;
    assign bus.st_eop         = fifo_valid && fifo_dout.eop;

`ifdef SSD_IMG_RD_CHECKSUM_EN
    logic [CSUM_W-1:0] csum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= '0;
        end else if (start_acc) begin
            csum <= '0;
        end else if (pop) begin
            csum <= csum_add(csum, head_data);
        end
    end

    assign bus.checksum = csum;
`endif

endmodule

// File: tb/tb_ssd_imagem_stream_reader.sv
module tb_ssd_imagem_stream_reader;

    logic clk;
    logic reset;

    ssd_imagem_stream_reader_if bus ();

    ssd_imagem_stream_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Synchronous RAM, read latency 1
    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        if (bus.mem_chipselect && bus.mem_clken) begin
            bus.mem_readdata <= ram[bus.mem_address];
        end
    end

    // Per-job observations (k = cycle index, k=0 is the cycle start is high)
    logic [7:0]  q_data [$];
    bit          q_sop  [$];
    bit          q_eop  [$];
    int          q_cyc  [$];
    logic [15:0] q_addr [$];
    int          done_cyc [$];
    bit          valid_hist [$];
    bit          busy_hist  [$];
    int          first_valid_cyc;
    int          max_out;
    int          unstable;
    int          clk_mismatch;
    bit          timed_out;

    task automatic run_job(input logic [15:0] base, input logic [16:0] len,
                           input int rmode, input int abort_at, input int max_cyc);
        int k, stop_at, issued, popped;
        bit stall_prev;
        logic [7:0] pd;
        logic ps, pe;
        q_data.delete(); q_sop.delete(); q_eop.delete(); q_cyc.delete();
        q_addr.delete(); done_cyc.delete(); valid_hist.delete(); busy_hist.delete();
        first_valid_cyc = -1; max_out = 0; unstable = 0; clk_mismatch = 0; timed_out = 0;
        k = 0; stop_at = -1; issued = 0; popped = 0; stall_prev = 0; pd = '0; ps = 0; pe = 0;
        while (1) begin
            @(negedge clk);
            bus.start     = (k == 0);
            bus.base_addr = base;
            bus.length    = len;
            bus.abort     = (k == abort_at);
            bus.st_ready  = (rmode == 0) ? 1'b1 : (rmode == 1) ? (k % 3 == 0) : 1'b0;
            #1;
            if (bus.mem_chipselect !== bus.mem_clken) clk_mismatch++;
            if (bus.mem_chipselect === 1'b1) begin
                q_addr.push_back(bus.mem_address);
                issued++;
            end
            if (stall_prev && (bus.st_valid !== 1'b1 || bus.st_data !== pd ||
                               bus.st_sop !== ps || bus.st_eop !== pe)) unstable++;
            if (bus.st_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = k;
            if (bus.st_valid === 1'b1 && bus.st_ready === 1'b1) begin
                q_data.push_back(bus.st_data);
                q_sop.push_back(bus.st_sop);
                q_eop.push_back(bus.st_eop);
                q_cyc.push_back(k);
                popped++;
            end
            stall_prev = (bus.st_valid === 1'b1) && (bus.st_ready !== 1'b1);
            pd = bus.st_data; ps = bus.st_sop; pe = bus.st_eop;
            if (issued - popped > max_out) max_out = issued - popped;
            valid_hist.push_back(bus.st_valid === 1'b1);
            busy_hist.push_back(bus.busy === 1'b1);
            if (bus.done === 1'b1) done_cyc.push_back(k);
            if (stop_at < 0 && (bus.done === 1'b1 || k == abort_at)) stop_at = k + 4;
            if (k == stop_at) break;
            if (k >= max_cyc) begin
                timed_out = 1;
                break;
            end
            k++;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.st_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if ({bus.busy, bus.done, bus.st_valid, bus.st_sop, bus.st_eop,
             bus.mem_chipselect, bus.mem_clken} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 0000000", {bus.busy, bus.done,
                     bus.st_valid, bus.st_sop, bus.st_eop, bus.mem_chipselect, bus.mem_clken});
        end
        tests_run++;
        if (bus.st_data !== 8'h00 || bus.mem_address !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_data: st_data %h addr %h, expected 00 0000", bus.st_data, bus.mem_address);
        end
`ifdef SSD_IMG_RD_CHECKSUM_EN
        tests_run++;
        if (bus.checksum !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_checksum: got %h expected 0000", bus.checksum);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if ({bus.busy, bus.st_valid, bus.mem_chipselect} !== 3'b000) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got %b expected 000", {bus.busy, bus.st_valid, bus.mem_chipselect});
        end
    endtask

    task automatic test_basic();
        run_job(16'h0010, 17'd4, 0, -1, 60);
        tests_run++;
        if (timed_out || q_data.size() != 4) begin
            tests_failed++;
            $display("FAIL basic_count: got %0d beats (timeout %0d) expected 4", q_data.size(), timed_out);
        end
        for (int i = 0; i < q_data.size(); i++) begin
            tests_run++;
            if (q_data[i] !== 8'(8'h10 + i) || q_sop[i] !== (i == 0) || q_eop[i] !== (i == 3) ||
                q_cyc[i] != 3 + i) begin
                tests_failed++;
                $display("FAIL basic_beat[%0d]: got d=%h sop=%0d eop=%0d cyc=%0d expected d=%h sop=%0d eop=%0d cyc=%0d",
                         i, q_data[i], q_sop[i], q_eop[i], q_cyc[i], 8'(8'h10 + i), (i == 0), (i == 3), 3 + i);
            end
        end
        tests_run++;
        if (first_valid_cyc != 3) begin
            tests_failed++;
            $display("FAIL basic_latency: first st_valid at %0d expected 3", first_valid_cyc);
        end
        tests_run++;
        if (done_cyc.size() != 1 || done_cyc[0] != 7) begin
            tests_failed++;
            $display("FAIL basic_done: %0d pulses first at %0d expected 1 pulse at 7",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
        end
        tests_run++;
        if (busy_hist[1] !== 1'b1 || busy_hist[7] !== 1'b1 || busy_hist[8] !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_busy: got k1=%0d k7=%0d k8=%0d expected 1 1 0", busy_hist[1], busy_hist[7], busy_hist[8]);
        end
        tests_run++;
        if (clk_mismatch != 0) begin
            tests_failed++;
            $display("FAIL basic_clken: %0d cycles chipselect!=clken expected 0", clk_mismatch);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_a [4];
        logic [7:0]  exp_d [4];
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        exp_d = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        run_job(16'hFFFE, 17'd4, 0, -1, 60);
        tests_run++;
        if (timed_out || q_addr.size() != 4 || q_data.size() != 4) begin
            tests_failed++;
            $display("FAIL wrap_count: got %0d reads %0d beats expected 4 4", q_addr.size(), q_data.size());
        end
        for (int i = 0; i < q_addr.size() && i < 4; i++) begin
            tests_run++;
            if (q_addr[i] !== exp_a[i]) begin
                tests_failed++;
                $display("FAIL wrap_addr[%0d]: got %h expected %h", i, q_addr[i], exp_a[i]);
            end
        end
        for (int i = 0; i < q_data.size() && i < 4; i++) begin
            tests_run++;
            if (q_data[i] !== exp_d[i]) begin
                tests_failed++;
                $display("FAIL wrap_data[%0d]: got %h expected %h", i, q_data[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int nsop, neop;
        run_job(16'h0040, 17'd16, 1, -1, 200);
        tests_run++;
        if (timed_out || q_data.size() != 16) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d beats (timeout %0d) expected 16", q_data.size(), timed_out);
        end
        nsop = 0; neop = 0;
        for (int i = 0; i < q_data.size(); i++) begin
            tests_run++;
            if (q_data[i] !== 8'(8'h40 + i)) begin
                tests_failed++;
                $display("FAIL bp_data[%0d]: got %h expected %h", i, q_data[i], 8'(8'h40 + i));
            end
            nsop += q_sop[i];
            neop += q_eop[i];
        end
        tests_run++;
        if (q_data.size() == 16 && (nsop != 1 || neop != 1 || q_sop[0] !== 1'b1 || q_eop[15] !== 1'b1)) begin
            tests_failed++;
            $display("FAIL bp_tags: got sop=%0d eop=%0d expected one sop on first, one eop on last", nsop, neop);
        end
        tests_run++;
        if (unstable != 0) begin
            tests_failed++;
            $display("FAIL bp_stable: got %0d changes while stalled expected 0", unstable);
        end
        tests_run++;
        if (max_out > 4) begin
            tests_failed++;
            $display("FAIL bp_outstanding: got %0d expected at most 4", max_out);
        end
        tests_run++;
        if (done_cyc.size() != 1 || q_cyc.size() != 16 || done_cyc[0] != q_cyc[15] + 1) begin
            tests_failed++;
            $display("FAIL bp_done: %0d pulses, not one cycle after last beat", done_cyc.size());
        end
    endtask

    task automatic test_len0_len1();
        run_job(16'h0050, 17'd0, 0, -1, 40);
        tests_run++;
        if (timed_out || done_cyc.size() != 1 || done_cyc[0] != 1) begin
            tests_failed++;
            $display("FAIL len0_done: %0d pulses first at %0d expected 1 pulse at 1",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
        end
        tests_run++;
        if (q_addr.size() != 0 || first_valid_cyc != -1) begin
            tests_failed++;
            $display("FAIL len0_quiet: got %0d reads, first valid %0d expected 0 reads, none", q_addr.size(), first_valid_cyc);
        end
        tests_run++;
        if (busy_hist[1] !== 1'b1 || busy_hist[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL len0_busy: got k1=%0d k2=%0d expected 1 0", busy_hist[1], busy_hist[2]);
        end
        run_job(16'h0077, 17'd1, 0, -1, 40);
        tests_run++;
        if (timed_out || q_data.size() != 1 || q_data[0] !== 8'h77 || q_sop[0] !== 1'b1 ||
            q_eop[0] !== 1'b1 || q_cyc[0] != 3) begin
            tests_failed++;
            $display("FAIL len1_beat: got %0d beats d=%h sop=%0d eop=%0d expected 1 beat 77 1 1 at 3",
                     q_data.size(), q_data.size() ? q_data[0] : 8'h00, q_sop.size() ? q_sop[0] : 1'b0,
                     q_eop.size() ? q_eop[0] : 1'b0);
        end
        tests_run++;
        if (done_cyc.size() != 1 || done_cyc[0] != 4) begin
            tests_failed++;
            $display("FAIL len1_done: %0d pulses expected 1 pulse at 4", done_cyc.size());
        end
    endtask

    task automatic test_abort();
        run_job(16'h0100, 17'd16, 2, 6, 40);
        tests_run++;
        if (q_addr.size() != 4 || max_out != 4) begin
            tests_failed++;
            $display("FAIL abort_fill: got %0d reads max %0d expected 4 4", q_addr.size(), max_out);
        end
        tests_run++;
        if (valid_hist[6] !== 1'b1 || valid_hist[7] !== 1'b0 || valid_hist[9] !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_valid: got k6=%0d k7=%0d k9=%0d expected 1 0 0", valid_hist[6], valid_hist[7], valid_hist[9]);
        end
        tests_run++;
        if (busy_hist[6] !== 1'b1 || busy_hist[7] !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_busy: got k6=%0d k7=%0d expected 1 0", busy_hist[6], busy_hist[7]);
        end
        tests_run++;
        if (done_cyc.size() != 0) begin
            tests_failed++;
            $display("FAIL abort_nodone: got %0d done pulses expected 0", done_cyc.size());
        end
        run_job(16'h0020, 17'd1, 0, -1, 40);
        tests_run++;
        if (timed_out || q_data.size() != 1 || q_data[0] !== 8'h20 || q_sop[0] !== 1'b1 ||
            q_eop[0] !== 1'b1 || done_cyc.size() != 1) begin
            tests_failed++;
            $display("FAIL abort_restart: got %0d beats first %h, %0d done expected 1 beat 20 with sop/eop, 1 done",
                     q_data.size(), q_data.size() ? q_data[0] : 8'h00, done_cyc.size());
        end
    endtask

    task automatic test_reset_midjob();
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = 16'h0200; bus.length = 17'd8; bus.st_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (bus.busy !== 1'b1 || bus.st_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL midjob_pre: got busy=%0d valid=%0d expected 1 1", bus.busy, bus.st_valid);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({bus.busy, bus.done, bus.st_valid, bus.st_sop, bus.st_eop, bus.mem_chipselect,
             bus.mem_clken} !== 7'b0 || bus.st_data !== 8'h00 || bus.mem_address !== 16'h0000) begin
            tests_failed++;
            $display("FAIL midjob_reset: got ctrl=%b data=%h addr=%h expected all 0",
                     {bus.busy, bus.done, bus.st_valid, bus.st_sop, bus.st_eop, bus.mem_chipselect,
                      bus.mem_clken}, bus.st_data, bus.mem_address);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.st_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.st_valid !== 1'b0 || bus.mem_chipselect !== 1'b0) begin
            tests_failed++;
            $display("FAIL midjob_after: got busy=%0d valid=%0d cs=%0d expected 0 0 0",
                     bus.busy, bus.st_valid, bus.mem_chipselect);
        end
    endtask

    task automatic test_checksum();
`ifdef SSD_IMG_RD_CHECKSUM_EN
        ram[16'h0300] = 8'hFF;
        ram[16'h0301] = 8'hFF;
        ram[16'h0302] = 8'h02;
        run_job(16'h0300, 17'd3, 0, -1, 40);
        tests_run++;
        if (timed_out || q_data.size() != 3) begin
            tests_failed++;
            $display("FAIL csum_count: got %0d beats expected 3", q_data.size());
        end
        tests_run++;
        if (bus.checksum !== 16'h0200) begin
            tests_failed++;
            $display("FAIL csum_value: got %h expected 0200", bus.checksum);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = i[7:0];
        bus.start = 1'b0; bus.abort = 1'b0; bus.base_addr = '0; bus.length = '0;
        bus.st_ready = 1'b1;
        reset = 1'b1;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_len0_len1();
        test_abort();
        test_reset_midjob();
        test_checksum();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
